prbs_data_checker: RTL and testbench
====================================

// Module: prbs_data_checker
// PURPOSE
//  Receive-side counterpart of the coder data imitator: checks a byte stream carrying
//  the O.150 PRBS-23 sequence (x^23+x^18+1), packed MSB-first (first bit in bit 7).
//  Self-synchronises to the incoming sequence, flags bit errors per byte and accumulates
//  BER statistics. Sits at the decoder/link output in loopback and BER test setups.
// PARAMETERS
//  SYNC_BITS   64  consecutive correctly predicted bits required to declare lock
//  LOSS_WIN    16  loss-of-sync observation window, in accepted bytes
//  LOSS_THR    32  bit errors within one window above which lock is dropped
//  CNT_W       32  width of statistics counters
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      asynchronous reset, active-low
//  clear_cnt    in   1      synchronous clear of bit_err_cnt / byte_cnt
//  data_in_en   in   1      data_in valid, one byte per cycle, gaps allowed
//  data_in      in   8      received byte, bit 7 = oldest bit
//  locked       out  1      1 = checker synchronised (LOCK state)
//  err_valid    out  1      one-cycle pulse per byte checked in LOCK
//  err_mask     out  8      XOR of received vs predicted bits for that byte
//  sync_loss    out  1      one-cycle pulse on LOCK->HUNT
//  bit_err_cnt  out  CNT_W  saturating count of errored bits while locked
//  byte_cnt     out  CNT_W  saturating count of bytes checked while locked
// BEHAVIOUR
//  - reset_n=0: all outputs and state 0 immediately; FSM=HUNT; LFSR=0; counters 0.
//  - LFSR r[22:0], r[0] newest bit; predicted bit p = r[17]^r[22]. Byte processed
//    combinationally as 8 serial steps, bit 7 first. Cycles with data_in_en=0: no change.
//  - Latency: all per-byte outputs registered, valid the cycle after data_in_en=1.
//  - HUNT: each bit b shifts in: r <= {r[21:0], b}. bits_seen saturates at 23. Once
//    bits_seen==23, p==b increments match_cnt, p!=b clears it. At byte end, if
//    match_cnt>=SYNC_BITS and r!=0 -> LOCK (locked=1 next cycle). All-zero register
//    never locks. No err_valid, no counting in HUNT or on the locking byte.
//  - LOCK: shift predicted bit in (r <= {r[21:0], p}) so errors never propagate;
//    err_mask = received ^ predicted; err_valid=1; byte_cnt += 1; bit_err_cnt +=
//    popcount(err_mask) (0..8), saturating at 2^CNT_W-1 (no wrap).
//  - Loss: win_bytes/win_errs accumulate in LOCK. On the LOSS_WIN-th byte, if
//    win_errs (including that byte) > LOSS_THR -> HUNT, sync_loss pulse, locked=0,
//    bits_seen/match_cnt/LFSR cleared; else window restarts. Statistics retained.
//  - clear_cnt=1: both counters 0 next cycle; a byte checked in the same cycle is
//    discarded from counters (clear wins); err_mask/err_valid still reported.
//  - clear_cnt does not affect FSM or window. reset_n mid-stream aborts everything.
// TESTING
//  1. Clean PRBS-23 stream from seed 23'h7FFFFF, 200 contiguous bytes -> locked
//     rises the cycle after byte 11; bit_err_cnt=0; byte_cnt=189; no sync_loss.
//  2. Locked, byte 50 XOR 8'h01 -> err_valid with err_mask=8'h01, bit_err_cnt=1,
//     following bytes err_mask=8'h00, locked stays 1.
//  3. 500 bytes of 8'h00 -> locked never asserts; err_valid never pulses.
//  4. Locked, 16 bytes of 8'hFF-inverted PRBS (128 errors) -> sync_loss one pulse
//     after 16th byte, locked=0; clean stream resumes -> relock after 11 bytes.
//  5. clear_cnt coincident with errored byte (mask 8'h0F) -> counters 0 next cycle;
//     err_mask=8'h0F reported; counting resumes on next byte.
//  6. Random data_in_en gaps in test 1 -> identical results; reset_n pulse mid-stream
//     -> outputs 0 asynchronously, relock from scratch.

Source files
------------

// File: rtl/prbs_data_checker.sv
// Receive-side PRBS-23 (x^23+x^18+1) checker: self-synchronises to an MSB-first byte
// stream, reports per-byte bit errors while locked and keeps saturating BER counters.
module prbs_data_checker #(
  parameter int SYNC_BITS = 64,
  parameter int LOSS_WIN  = 16,
  parameter int LOSS_THR  = 32,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_cnt,
  input  logic             data_in_en,
  input  logic [7:0]       data_in,
  output logic             locked,
  output logic             err_valid,
  output logic [7:0]       err_mask,
  output logic             sync_loss,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] byte_cnt
);

  localparam int MC_W = $clog2(SYNC_BITS + 1);
  localparam int WB_W = $clog2(LOSS_WIN + 1);
  localparam int WE_W = $clog2(LOSS_WIN * 8 + 1);
  localparam logic [MC_W-1:0] SYNC_V = MC_W'(SYNC_BITS);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [22:0]      lfsr_reg, lfsr_next;
  logic [4:0]       bits_seen_reg, bits_seen_next;
  logic [MC_W-1:0]  match_cnt_reg, match_cnt_next;
  logic [WB_W-1:0]  win_bytes_reg, win_bytes_next;
  logic [WE_W-1:0]  win_errs_reg, win_errs_next;
  logic             err_valid_reg, err_valid_next;
  logic [7:0]       err_mask_reg, err_mask_next;
  logic             sync_loss_reg, sync_loss_next;
  logic [CNT_W-1:0] bit_err_cnt_reg, bit_err_cnt_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;

  // Per-byte serial walk results
  logic [22:0]      r_c;
  logic [4:0]       bs_c;
  logic [MC_W-1:0]  mc_c;
  logic [7:0]       mask_c;
  logic [3:0]       errs_c;
  logic             p_c;
  logic [WE_W-1:0]  win_sum_c;
  logic [CNT_W:0]   err_sum_c;
  logic [CNT_W:0]   byte_sum_c;

  always_comb begin
    r_c    = lfsr_reg;
    bs_c   = bits_seen_reg;
    mc_c   = match_cnt_reg;
    mask_c = 8'h00;
    errs_c = 4'd0;
    p_c    = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      p_c = r_c[17] ^ r_c[22];
      if (state_reg == HUNT) begin
        if (bs_c == 5'd23) begin
          if (p_c == data_in[i]) begin
            if (mc_c < SYNC_V) mc_c = mc_c + MC_W'(1);
          end else begin
            mc_c = '0;
          end
        end else begin
          bs_c = bs_c + 5'd1;
        end
        r_c = {r_c[21:0], data_in[i]};
      end else begin
        // Locked: the prediction feeds the register, so a bit error never propagates
        mask_c[i] = data_in[i] ^ p_c;
        r_c = {r_c[21:0], p_c};
      end
    end
    for (int i = 0; i < 8; i++) errs_c = errs_c + {3'b000, mask_c[i]};
  end

  assign win_sum_c  = win_errs_reg + WE_W'(errs_c);
  assign err_sum_c  = {1'b0, bit_err_cnt_reg} + (CNT_W+1)'(errs_c);
  assign byte_sum_c = {1'b0, byte_cnt_reg} + (CNT_W+1)'(1);

  always_comb begin
    state_next       = state_reg;
    lfsr_next        = lfsr_reg;
    bits_seen_next   = bits_seen_reg;
    match_cnt_next   = match_cnt_reg;
    win_bytes_next   = win_bytes_reg;
    win_errs_next    = win_errs_reg;
    err_valid_next   = 1'b0;
    err_mask_next    = err_mask_reg;
    sync_loss_next   = 1'b0;
    bit_err_cnt_next = bit_err_cnt_reg;
    byte_cnt_next    = byte_cnt_reg;

    if (data_in_en) begin
      lfsr_next = r_c;
      if (state_reg == HUNT) begin
        bits_seen_next = bs_c;
        match_cnt_next = mc_c;
        if (mc_c >= SYNC_V && r_c != 23'd0) begin
          state_next     = LOCK;
          win_bytes_next = '0;
          win_errs_next  = '0;
        end
      end else begin
        err_valid_next   = 1'b1;
        err_mask_next    = mask_c;
        bit_err_cnt_next = err_sum_c[CNT_W] ? '1 : err_sum_c[CNT_W-1:0];
        byte_cnt_next    = byte_sum_c[CNT_W] ? '1 : byte_sum_c[CNT_W-1:0];
        win_bytes_next   = win_bytes_reg + WB_W'(1);
        win_errs_next    = win_sum_c;
        if (win_bytes_reg == WB_W'(LOSS_WIN - 1)) begin
          win_bytes_next = '0;
          win_errs_next  = '0;
          if (win_sum_c > WE_W'(LOSS_THR)) begin
            state_next     = HUNT;
            sync_loss_next = 1'b1;
            lfsr_next      = '0;
            bits_seen_next = '0;
            match_cnt_next = '0;
          end
        end
      end
    end

    // Clear wins over any byte counted in the same cycle
    if (clear_cnt) begin
      bit_err_cnt_next = '0;
      byte_cnt_next    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= HUNT;
      lfsr_reg        <= '0;
      bits_seen_reg   <= '0;
      match_cnt_reg   <= '0;
      win_bytes_reg   <= '0;
      win_errs_reg    <= '0;
      err_valid_reg   <= 1'b0;
      err_mask_reg    <= '0;
      sync_loss_reg   <= 1'b0;
      bit_err_cnt_reg <= '0;
      byte_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      lfsr_reg        <= lfsr_next;
      bits_seen_reg   <= bits_seen_next;
      match_cnt_reg   <= match_cnt_next;
      win_bytes_reg   <= win_bytes_next;
      win_errs_reg    <= win_errs_next;
      err_valid_reg   <= err_valid_next;
      err_mask_reg    <= err_mask_next;
      sync_loss_reg   <= sync_loss_next;
      bit_err_cnt_reg <= bit_err_cnt_next;
      byte_cnt_reg    <= byte_cnt_next;
    end
  end

  assign locked      = (state_reg == LOCK);
  assign err_valid   = err_valid_reg;
  assign err_mask    = err_mask_reg;
  assign sync_loss   = sync_loss_reg;
  assign bit_err_cnt = bit_err_cnt_reg;
  assign byte_cnt    = byte_cnt_reg;

endmodule

// File: tb/tb_prbs_data_checker.sv
// Directed bench for prbs_data_checker: a PRBS-23 transmitter model feeds clean,
// corrupted and gapped byte streams; each scenario task checks its own results.
module tb_prbs_data_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        data_in_en = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        locked, err_valid, sync_loss;
  logic [7:0]  err_mask;
  logic [31:0] bit_err_cnt, byte_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [22:0] gen;

  prbs_data_checker dut (
    .clk(clk), .reset_n(reset_n), .clear_cnt(clear_cnt), .data_in_en(data_in_en),
    .data_in(data_in), .locked(locked), .err_valid(err_valid), .err_mask(err_mask),
    .sync_loss(sync_loss), .bit_err_cnt(bit_err_cnt), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // Transmitter: each new bit = g[17]^g[22], MSB-first packing
  task automatic next_prbs(output logic [7:0] b);
    logic nb;
    for (int i = 7; i >= 0; i--) begin
      nb = gen[17] ^ gen[22];
      b[i] = nb;
      gen = {gen[21:0], nb};
    end
  endtask

  task automatic send(input logic [7:0] d, input logic clr);
    @(negedge clk);
    data_in = d;
    data_in_en = 1'b1;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    data_in_en = 1'b0;
    clear_cnt = 1'b0;
    $display("byte %02h clr=%0b -> locked=%0b ev=%0b mask=%02h sl=%0b errs=%0d bytes=%0d",
             d, clr, locked, err_valid, err_mask, sync_loss, bit_err_cnt, byte_cnt);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    data_in_en = 1'b0;
    clear_cnt = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    gen = 23'h7FFFFF;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({locked, err_valid, err_mask, sync_loss} !== 11'd0) begin
      $display("FAIL reset_flags: got %0b/%0b/%02h/%0b required all 0", locked, err_valid, err_mask, sync_loss);
    end else pass_cnt++;
    total_cnt++;
    if (bit_err_cnt !== 32'd0 || byte_cnt !== 32'd0) begin
      $display("FAIL reset_counters: got %0d/%0d required 0/0", bit_err_cnt, byte_cnt);
    end else pass_cnt++;
  endtask

  task automatic test_lock(input bit gaps);
    logic [7:0] d;
    int lock_at = 0, ev = 0, sl = 0, errs = 0;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      next_prbs(d);
      send(d, 1'b0);
      if (locked && lock_at == 0) lock_at = k;
      if (err_valid) begin
        ev++;
        errs += $countones(err_mask);
      end
      if (sync_loss) sl++;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    total_cnt++;
    if (lock_at !== 11) $display("FAIL lock_byte(gaps=%0b): got %0d required 11", gaps, lock_at);
    else pass_cnt++;
    total_cnt++;
    if (ev !== 189 || errs !== 0) $display("FAIL err_pulses(gaps=%0b): got %0d pulses %0d errs required 189/0", gaps, ev, errs);
    else pass_cnt++;
    total_cnt++;
    if (byte_cnt !== 32'd189 || bit_err_cnt !== 32'd0) begin
      $display("FAIL clean_counters(gaps=%0b): got %0d/%0d required 189/0", gaps, byte_cnt, bit_err_cnt);
    end else pass_cnt++;
    total_cnt++;
    if (sl !== 0 || locked !== 1'b1) $display("FAIL clean_sync(gaps=%0b): got sl=%0d locked=%0b required 0/1", gaps, sl, locked);
    else pass_cnt++;
  endtask

  task automatic test_single_error();
    logic [7:0] d;
    int bad = 0, unlocked = 0;
    do_reset();
    for (int k = 1; k <= 49; k++) begin
      next_prbs(d);
      send(d, 1'b0);
    end
    next_prbs(d);
    send(d ^ 8'h01, 1'b0);
    total_cnt++;
    if (err_valid !== 1'b1 || err_mask !== 8'h01) begin
      $display("FAIL single_err_mask: got ev=%0b mask=%02h required 1/01", err_valid, err_mask);
    end else pass_cnt++;
    total_cnt++;
    if (bit_err_cnt !== 32'd1 || byte_cnt !== 32'd39) begin
      $display("FAIL single_err_counts: got %0d/%0d required 1/39", bit_err_cnt, byte_cnt);
    end else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      next_prbs(d);
      send(d, 1'b0);
      if (!err_valid || err_mask !== 8'h00) bad++;
      if (!locked) unlocked++;
    end
    total_cnt++;
    if (bad !== 0 || unlocked !== 0) $display("FAIL single_err_followup: got %0d bad %0d unlocked required 0/0", bad, unlocked);
    else pass_cnt++;
  endtask

  task automatic test_all_zero();
    int lk = 0, ev = 0;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      send(8'h00, 1'b0);
      if (locked) lk++;
      if (err_valid) ev++;
    end
    total_cnt++;
    if (lk !== 0 || ev !== 0) $display("FAIL all_zero: got %0d locked %0d err_valid required 0/0", lk, ev);
    else pass_cnt++;
  endtask

  task automatic test_sync_loss();
    logic [7:0] d;
    int sl = 0, relock = 0;
    do_reset();
    // 11 to lock plus one full clean window, so the bad burst fills exactly one window
    for (int k = 0; k < 27; k++) begin
      next_prbs(d);
      send(d, 1'b0);
    end
    for (int k = 1; k <= 16; k++) begin
      next_prbs(d);
      send(~d, 1'b0);
      if (sync_loss) sl++;
      if (k == 15) begin
        total_cnt++;
        if (locked !== 1'b1 || sync_loss !== 1'b0) $display("FAIL loss_early: got locked=%0b sl=%0b required 1/0", locked, sync_loss);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (sync_loss !== 1'b1 || locked !== 1'b0) $display("FAIL loss_pulse: got sl=%0b locked=%0b required 1/0", sync_loss, locked);
    else pass_cnt++;
    total_cnt++;
    if (bit_err_cnt !== 32'd128 || byte_cnt !== 32'd32) $display("FAIL loss_counts: got %0d/%0d required 128/32", bit_err_cnt, byte_cnt);
    else pass_cnt++;
    for (int k = 1; k <= 20; k++) begin
      next_prbs(d);
      send(d, 1'b0);
      if (sync_loss) sl++;
      if (locked && relock == 0) relock = k;
    end
    total_cnt++;
    if (sl !== 1 || relock !== 11) $display("FAIL relock: got %0d pulses relock at %0d required 1/11", sl, relock);
    else pass_cnt++;
  endtask

  task automatic test_clear_cnt();
    logic [7:0] d;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      next_prbs(d);
      send(d, 1'b0);
    end
    next_prbs(d);
    send(d ^ 8'h0F, 1'b1);
    total_cnt++;
    if (err_valid !== 1'b1 || err_mask !== 8'h0F || locked !== 1'b1) begin
      $display("FAIL clear_mask: got ev=%0b mask=%02h locked=%0b required 1/0f/1", err_valid, err_mask, locked);
    end else pass_cnt++;
    total_cnt++;
    if (bit_err_cnt !== 32'd0 || byte_cnt !== 32'd0) $display("FAIL clear_counts: got %0d/%0d required 0/0", bit_err_cnt, byte_cnt);
    else pass_cnt++;
    next_prbs(d);
    send(d ^ 8'h03, 1'b0);
    total_cnt++;
    if (bit_err_cnt !== 32'd2 || byte_cnt !== 32'd1) $display("FAIL clear_resume: got %0d/%0d required 2/1", bit_err_cnt, byte_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_midstream();
    logic [7:0] d;
    int relock = 0;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      next_prbs(d);
      send(d, 1'b1 == 1'b0);
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (locked !== 1'b0 || byte_cnt !== 32'd0 || err_valid !== 1'b0) begin
      $display("FAIL async_reset: got locked=%0b bytes=%0d ev=%0b required 0/0/0", locked, byte_cnt, err_valid);
    end else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      next_prbs(d);
      send(d, 1'b0);
      if (locked && relock == 0) relock = k;
    end
    total_cnt++;
    if (relock !== 11 || byte_cnt !== 32'd9) $display("FAIL reset_relock: got relock %0d bytes %0d required 11/9", relock, byte_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lock(1'b0);
    test_single_error();
    test_all_zero();
    test_sync_loss();
    test_clear_cnt();
    test_lock(1'b1);
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
